pmu_i2c_target: RTL and testbench



---
 rtl/pmu_i2c_wr_if.sv | 10 +
 rtl/pmu_i2c_target.sv | 191 +++++++++++++++++++
 tb/tb_pmu_i2c_target.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pmu_i2c_wr_if.sv
// Write-report bus of the PMU I2C target: one strobe per accepted data byte,
// carrying the subaddress and data of that byte.
interface pmu_i2c_wr_if;
    logic       wr_strobe;
    logic [7:0] wr_subaddr;
    logic [7:0] wr_data;

    modport master (output wr_strobe, wr_subaddr, wr_data);
    modport slave  (input  wr_strobe, wr_subaddr, wr_data);
endinterface

// File: rtl/pmu_i2c_target.sv
// I2C target emulating the PMU register file at a 7-bit address; SCL/SDA are
// oversampled on clk, writes are stored and reported, reads are served MSB first.
module pmu_i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h34,
    parameter logic [7:0] RST_EN   = 8'h80,
    parameter logic [7:0] RST_DAC  = 8'h00
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         scl,
    inout  wire          sda,
    output logic [7:0]   reg_en,
    output logic [7:0]   reg_slew,
    output logic [7:0]   reg_dac0,
    output logic [7:0]   reg_dac1,
    output logic [7:0]   reg_dac2,
    output logic         busy,
    pmu_i2c_wr_if.master wr
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_SUB       = 4'd3;
    localparam logic [3:0] S_SUB_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RACK      = 4'd8;

    logic       scl_p0, scl_p1, scl_p2;
    logic       sda_p0, sda_p1, sda_p2;
    logic       scl_rise, scl_fall, bus_start, bus_stop;
    logic [3:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] rx_byte;
    logic [7:0] ptr;
    logic [7:0] rd_data;
    logic       rw;
    logic       sda_low;

    // Open-drain output; reset releases the line combinationally.
    assign sda = (sda_low && !reset) ? 1'b0 : 1'bz;

    // Stage p1 is the synchronized level, p2 the one-cycle history.
    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    assign bus_start =  scl_p1 &  scl_p2 &  sda_p2 & ~sda_p1;
    assign bus_stop  =  scl_p1 &  scl_p2 & ~sda_p2 &  sda_p1;
    assign rx_byte   = {shreg[6:0], sda_p1};

    always_comb begin
        rd_data = 8'h00;
        case (ptr)
            8'h10:   rd_data = reg_en;
            8'h20:   rd_data = reg_slew;
            8'h26:   rd_data = reg_dac1;
            8'h29:   rd_data = reg_dac2;
            8'h32:   rd_data = reg_dac0;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_p0       <= 1'b1;
            scl_p1       <= 1'b1;
            scl_p2       <= 1'b1;
            sda_p0       <= 1'b1;
            sda_p1       <= 1'b1;
            sda_p2       <= 1'b1;
            state        <= S_IDLE;
            bit_cnt      <= 4'd0;
            sda_low      <= 1'b0;
            busy         <= 1'b0;
            ptr          <= 8'h00;
            wr.wr_strobe <= 1'b0;
            reg_en       <= RST_EN;
            reg_slew     <= 8'h00;
            reg_dac0     <= RST_DAC;
            reg_dac1     <= RST_DAC;
            reg_dac2     <= RST_DAC;
        end else begin
            scl_p0       <= scl;
            scl_p1       <= scl_p0;
            scl_p2       <= scl_p1;
            sda_p0       <= sda;
            sda_p1       <= sda_p0;
            sda_p2       <= sda_p1;
            wr.wr_strobe <= 1'b0;

            if (bus_start) begin
                state   <= S_ADDR;
                bit_cnt <= 4'd0;
                busy    <= 1'b1;
                sda_low <= 1'b0;
            end else if (bus_stop) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                sda_low <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_SUB, S_WDATA: begin
                        // bit_cnt==8 means the byte is complete and the ACK is pending.
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (state == S_ADDR) begin
                                    if (rx_byte[7:1] == DEV_ADDR) rw <= rx_byte[0];
                                    else                          state <= S_IDLE;
                                end else if (state == S_SUB) begin
                                    ptr <= rx_byte;
                                end else begin
                                    case (ptr)
                                        8'h10:   reg_en   <= rx_byte;
                                        8'h20:   reg_slew <= rx_byte;
                                        8'h26:   reg_dac1 <= rx_byte;
                                        8'h29:   reg_dac2 <= rx_byte;
                                        8'h32:   reg_dac0 <= rx_byte;
                                        default: ;
                                    endcase
                                    wr.wr_strobe  <= 1'b1;
                                    wr.wr_subaddr <= ptr;
                                    wr.wr_data    <= rx_byte;
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_low <= 1'b1;
                            state   <= (state == S_ADDR) ? S_ADDR_ACK :
                                       (state == S_SUB)  ? S_SUB_ACK  : S_WDATA_ACK;
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (!rw) begin
                                sda_low <= 1'b0;
                                state   <= S_SUB;
                            end else begin
                                shreg   <= rd_data;
                                sda_low <= ~rd_data[7];
                                state   <= S_RDATA;
                            end
                        end
                    end
                    S_SUB_ACK, S_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_low <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= S_WDATA;
                            if (state == S_WDATA_ACK) ptr <= ptr + 8'd1;
                        end
                    end
                    S_RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                sda_low <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= S_RACK;
                            end else begin
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_low <= ~shreg[6];
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_RACK: begin
                        // Master ACK advances ptr on the rising edge; next byte loads on the fall.
                        if (scl_rise && bit_cnt != 4'd8) begin
                            if (sda_p1) begin
                                state <= S_IDLE;
                            end else begin
                                ptr     <= ptr + 8'd1;
                                bit_cnt <= 4'd8;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            shreg   <= rd_data;
                            sda_low <= ~rd_data[7];
                            bit_cnt <= 4'd0;
                            state   <= S_RDATA;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pmu_i2c_target.sv
// Bench for pmu_i2c_target: bit-banged I2C master, write-strobe scoreboard,
// and direct checks of ACKs, read data and register outputs.
module tb_pmu_i2c_target;
    localparam int Q = 50;  // quarter SCL period in ns (5 clk)

    typedef struct packed {
        logic [7:0] sub;
        logic [7:0] dat;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic [7:0] reg_en, reg_slew, reg_dac0, reg_dac1, reg_dac2;
    logic       busy;
    int         n_cmp = 0;
    int         n_err = 0;
    int         dut_low = 0;
    wr_t        exp_q[$];

    pmu_i2c_wr_if wr_if();

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    pmu_i2c_target dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .reg_en   (reg_en),
        .reg_slew (reg_slew),
        .reg_dac0 (reg_dac0),
        .reg_dac1 (reg_dac1),
        .reg_dac2 (reg_dac2),
        .busy     (busy),
        .wr       (wr_if)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Cycles where the target, not the master, holds SDA low.
    always @(posedge clk) begin
        if (!m_low && sda === 1'b0) dut_low++;
    end

    always @(negedge clk) begin
        if (wr_if.wr_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wr_unexpected: got sub 0x%02h data 0x%02h, expected no strobe",
                         wr_if.wr_subaddr, wr_if.wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_subaddr", wr_if.wr_subaddr, e.sub);
                check("wr_data", wr_if.wr_data, e.dat);
            end
        end
    end

    task automatic bit_xfer(input logic b, output logic s);
        m_low = ~b;
        #Q; scl = 1'b1;
        #Q; s = sda;
        #Q; scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_start();
        m_low = 1'b0;
        #Q; scl = 1'b1;
        #Q; m_low = 1'b1;
        #Q; scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        m_low = 1'b1;
        #Q; scl = 1'b1;
        #Q; m_low = 1'b0;
        #Q; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_n);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack_n);
    endtask

    task automatic read_byte(input logic nak, output logic [7:0] d, output logic ack_line);
        logic s;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(nak, ack_line);
    endtask

    task automatic wr_txn(input logic [7:0] sub, input logic [7:0] dat, input string nm);
        logic a;
        i2c_start();
        write_byte(8'h68, a); check({nm, "_addr_ack"}, {7'd0, a}, 8'h00);
        write_byte(sub, a);   check({nm, "_sub_ack"},  {7'd0, a}, 8'h00);
        exp_q.push_back('{sub: sub, dat: dat});
        write_byte(dat, a);   check({nm, "_data_ack"}, {7'd0, a}, 8'h00);
        i2c_stop();
    endtask

    initial begin
        logic       a, s;
        logic [7:0] d;
        int         low_before;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_sda", {7'd0, sda}, 8'h01);
        check("rst_reg_en", reg_en, 8'h80);
        check("rst_reg_slew", reg_slew, 8'h00);
        check("rst_reg_dac0", reg_dac0, 8'h00);
        check("rst_reg_dac1", reg_dac1, 8'h00);
        check("rst_reg_dac2", reg_dac2, 8'h00);
        check("rst_wr_strobe", {7'd0, wr_if.wr_strobe}, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single-byte write to enable register.
        i2c_start();
        check("t1_busy_start", {7'd0, busy}, 8'h01);
        write_byte(8'h68, a); check("t1_addr_ack", {7'd0, a}, 8'h00);
        write_byte(8'h10, a); check("t1_sub_ack", {7'd0, a}, 8'h00);
        exp_q.push_back('{sub: 8'h10, dat: 8'h9D});
        write_byte(8'h9D, a); check("t1_data_ack", {7'd0, a}, 8'h00);
        check("t1_busy_before_stop", {7'd0, busy}, 8'h01);
        i2c_stop();
        check("t1_busy_after_stop", {7'd0, busy}, 8'h00);
        check("t1_reg_en", reg_en, 8'h9D);

        // Auto-increment into an unmapped subaddress.
        i2c_start();
        write_byte(8'h68, a); check("t2_addr_ack", {7'd0, a}, 8'h00);
        write_byte(8'h20, a); check("t2_sub_ack", {7'd0, a}, 8'h00);
        exp_q.push_back('{sub: 8'h20, dat: 8'h55});
        write_byte(8'h55, a); check("t2_data0_ack", {7'd0, a}, 8'h00);
        exp_q.push_back('{sub: 8'h21, dat: 8'h11});
        write_byte(8'h11, a); check("t2_data1_ack", {7'd0, a}, 8'h00);
        i2c_stop();
        check("t2_reg_slew", reg_slew, 8'h55);

        // Preload dac0, then read it back through a repeated START.
        wr_txn(8'h32, 8'h1A, "t3_pre");
        check("t3_reg_dac0", reg_dac0, 8'h1A);
        i2c_start();
        write_byte(8'h68, a); check("t3_addr_ack", {7'd0, a}, 8'h00);
        write_byte(8'h32, a); check("t3_sub_ack", {7'd0, a}, 8'h00);
        i2c_start();
        write_byte(8'h69, a); check("t3_raddr_ack", {7'd0, a}, 8'h00);
        read_byte(1'b1, d, s);
        check("t3_rd_data", d, 8'h1A);
        check("t3_sda_released_nak", {7'd0, s}, 8'h01);
        i2c_stop();

        // Two-byte read: enable register, then unmapped 0x11 reads zero.
        i2c_start();
        write_byte(8'h68, a);
        write_byte(8'h10, a);
        i2c_start();
        write_byte(8'h69, a); check("t3b_raddr_ack", {7'd0, a}, 8'h00);
        read_byte(1'b0, d, s); check("t3b_rd0", d, 8'h9D);
        read_byte(1'b1, d, s); check("t3b_rd1", d, 8'h00);
        check("t3b_sda_released_nak", {7'd0, s}, 8'h01);
        i2c_stop();

        // Foreign address 0x35: never acknowledged, never driven.
        low_before = dut_low;
        i2c_start();
        write_byte(8'h6A, a); check("t4_nak", {7'd0, a}, 8'h01);
        write_byte(8'h10, a);
        i2c_stop();
        check("t4_no_drive", 8'(dut_low - low_before), 8'h00);
        check("t4_reg_en_kept", reg_en, 8'h9D);
        wr_txn(8'h26, 8'h44, "t4_next");
        check("t4_reg_dac1", reg_dac1, 8'h44);

        // STOP after four data bits: nothing stored or strobed.
        i2c_start();
        write_byte(8'h68, a);
        write_byte(8'h29, a); check("t5_sub_ack", {7'd0, a}, 8'h00);
        bit_xfer(1'b1, s); bit_xfer(1'b0, s); bit_xfer(1'b1, s); bit_xfer(1'b0, s);
        i2c_stop();
        check("t5_reg_dac2", reg_dac2, 8'h00);
        check("t5_busy", {7'd0, busy}, 8'h00);

        // Reset while the target is driving the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_xfer(((8'h68 >> i) & 1) != 0, s);
        m_low = 1'b0;
        #Q;
        check("t6_ack_driven", {7'd0, sda}, 8'h00);
        reset = 1'b1;
        #1;
        check("t6_sda_released", {7'd0, sda}, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        check("t6_reg_en", reg_en, 8'h80);
        check("t6_reg_slew", reg_slew, 8'h00);
        check("t6_reg_dac0", reg_dac0, 8'h00);
        check("t6_reg_dac1", reg_dac1, 8'h00);
        check("t6_busy", {7'd0, busy}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        scl = 1'b1;
        #(2*Q); scl = 1'b0;
        #Q;
        i2c_stop();
        wr_txn(8'h10, 8'h3C, "t6_after");
        check("t6_reg_en_after", reg_en, 8'h3C);

        repeat (10) @(negedge clk);
        check("wr_pending", 8'(exp_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
